// File: rtl/inst_buffer.sv
// ----------------------------------------------------------------------------
// inst_buffer
//   Dual-issue instruction buffer between fetch and decode. It is a circular
//   FIFO of DEPTH entries. It accepts up to two instructions per cycle from
//   fetch and presents up to two per cycle to decode.
//
// Parameters
//   DEPTH  number of entries (power of two, >= 4)
//   PTR_W  log2(DEPTH)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush_i           clear the buffer; same-cycle pushes are discarded
//   stall_i           decode stall; nothing is issued while high
//   single_issue_i    decode accepts at most one instruction this cycle
//   fetch_valid_i     fetch slot valids (2'b00 / 2'b01 / 2'b11)
//   fetch_inst*/pc*   fetched instructions and their PCs
//   id_inst*/pc*      instructions at head and head+1 (zero when not valid)
//   id_valid0/1_o     slot issued this cycle
//   ibuf_full_o       backpressure: fewer than two free entries
//   ibuf_empty_o      buffer holds no entries
//
// Optional feature (macro IBUF_PERF_CNT_EN)
//   perf_full_cycles_o   cycles with full and fetch offering instructions
//   perf_empty_cycles_o  cycles with empty and decode not stalled
//   Both counters saturate and are cleared only by rst.
// ----------------------------------------------------------------------------
module inst_buffer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              single_issue_i,
  input  logic [1:0]        fetch_valid_i,
  input  logic [31:0]       fetch_inst0_i,
  input  logic [31:0]       fetch_pc0_i,
  input  logic [31:0]       fetch_inst1_i,
  input  logic [31:0]       fetch_pc1_i,
  output logic [31:0]       id_inst0_o,
  output logic [31:0]       id_pc0_o,
  output logic              id_valid0_o,
  output logic [31:0]       id_inst1_o,
  output logic [31:0]       id_pc1_o,
  output logic              id_valid1_o,
  output logic              ibuf_full_o,
  output logic              ibuf_empty_o
`ifdef IBUF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_full_cycles_o,
  output logic [31:0]       perf_empty_cycles_o
`endif
);

  localparam logic [PTR_W:0]   FULL_LIMIT = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0]   DEPTH_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [1:0]       fetch_ok;
  logic [1:0]       push_num;
  logic [1:0]       issue_avail;
  logic [1:0]       pop_num;

  assign head_p1 = head + PTR_ONE;
  assign tail_p1 = tail + PTR_ONE;

  assign ibuf_full_o  = (count > FULL_LIMIT);
  assign ibuf_empty_o = (count == '0);

  // The illegal pattern 2'b10 is squashed to "no instructions".
  assign fetch_ok = (fetch_valid_i == 2'b10) ? 2'b00 : fetch_valid_i;
  // The full check uses the current count, so a same-cycle pop does not
  // open room for a push.
  assign push_num = ibuf_full_o ? 2'd0
                                : ({1'b0, fetch_ok[0]} + {1'b0, fetch_ok[1]});

  always_comb begin
    issue_avail = 2'd2;
    if (count == '0)
      issue_avail = 2'd0;
    else if (single_issue_i || count == (PTR_W+1)'(1))
      issue_avail = 2'd1;
  end

  assign pop_num     = (stall_i || flush_i) ? 2'd0 : issue_avail;
  assign id_valid0_o = (pop_num != 2'd0);
  assign id_valid1_o = (pop_num == 2'd2);

  assign id_inst0_o = id_valid0_o ? inst_q[head]    : '0;
  assign id_pc0_o   = id_valid0_o ? pc_q[head]      : '0;
  assign id_inst1_o = id_valid1_o ? inst_q[head_p1] : '0;
  assign id_pc1_o   = id_valid1_o ? pc_q[head_p1]   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every right-hand side sees the
      // pre-edge state and the order of these lines does not matter.
      head  <= head + {{(PTR_W-2){1'b0}}, pop_num};
      tail  <= tail + {{(PTR_W-2){1'b0}}, push_num};
      count <= count + {{(PTR_W-1){1'b0}}, push_num}
                     - {{(PTR_W-1){1'b0}}, pop_num};
    end
  end

  // NOTE: the entry arrays carry no reset; count gates every read, so stale
  // contents are never observable and the arrays can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      if (push_num != 2'd0) begin
        inst_q[tail] <= fetch_inst0_i;
        pc_q[tail]   <= fetch_pc0_i;
      end
      if (push_num == 2'd2) begin
        inst_q[tail_p1] <= fetch_inst1_i;
        pc_q[tail_p1]   <= fetch_pc1_i;
      end
    end
  end

`ifdef IBUF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cycles_o  <= '0;
      perf_empty_cycles_o <= '0;
    end else begin
      if (ibuf_full_o && fetch_valid_i != 2'b00 && perf_full_cycles_o != '1)
        perf_full_cycles_o <= perf_full_cycles_o + 32'd1;
      if (ibuf_empty_o && !stall_i && perf_empty_cycles_o != '1)
        perf_empty_cycles_o <= perf_empty_cycles_o + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

`ifndef SYNTHESIS
  a_legal_fetch_valid: assert property (
    @(posedge clk) disable iff (rst) fetch_valid_i != 2'b10);
  a_count_max: assert property (
    @(posedge clk) disable iff (rst) count <= DEPTH_CNT);
  a_count_no_underflow: assert property (
    @(posedge clk) disable iff (rst) count >= {{(PTR_W-1){1'b0}}, pop_num});
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// ----------------------------------------------------------------------------
// tb_inst_buffer
//   Randomized and directed stimulus for inst_buffer. The reference model is
//   a queue of {inst, pc} entries. Expected outputs come from the queue
//   contents and the buffer's issue and push rules.
// ----------------------------------------------------------------------------
module tb_inst_buffer;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        stall_i;
  logic        single_issue_i;
  logic [1:0]  fetch_valid_i;
  logic [31:0] fetch_inst0_i, fetch_pc0_i, fetch_inst1_i, fetch_pc1_i;
  logic [31:0] id_inst0_o, id_pc0_o, id_inst1_o, id_pc1_o;
  logic        id_valid0_o, id_valid1_o, ibuf_full_o, ibuf_empty_o;
`ifdef IBUF_PERF_CNT_EN
  logic [31:0] perf_full_cycles_o, perf_empty_cycles_o;
  logic [31:0] perf_full_m, perf_empty_m;
`endif

  entry_t      fifo[$];
  logic [31:0] pc_ctr;
  int          total = 0;
  int          bad   = 0;

  inst_buffer #(.DEPTH(DEPTH), .PTR_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .stall_i        (stall_i),
    .single_issue_i (single_issue_i),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_inst0_i  (fetch_inst0_i),
    .fetch_pc0_i    (fetch_pc0_i),
    .fetch_inst1_i  (fetch_inst1_i),
    .fetch_pc1_i    (fetch_pc1_i),
    .id_inst0_o     (id_inst0_o),
    .id_pc0_o       (id_pc0_o),
    .id_valid0_o    (id_valid0_o),
    .id_inst1_o     (id_inst1_o),
    .id_pc1_o       (id_pc1_o),
    .id_valid1_o    (id_valid1_o),
    .ibuf_full_o    (ibuf_full_o),
    .ibuf_empty_o   (ibuf_empty_o)
`ifdef IBUF_PERF_CNT_EN
    ,
    .perf_full_cycles_o  (perf_full_cycles_o),
    .perf_empty_cycles_o (perf_empty_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model by the same edge.
  task automatic step(input logic r, input logic fl, input logic st,
                      input logic si, input logic [1:0] fv);
    int     n;
    int     lim;
    int     pop_n;
    logic   full_m;
    logic   empty_m;
    entry_t e0, e1;
    @(negedge clk);
    rst            = r;
    flush_i        = fl;
    stall_i        = st;
    single_issue_i = si;
    fetch_valid_i  = fv;
    fetch_inst0_i  = $urandom;
    fetch_inst1_i  = $urandom;
    fetch_pc0_i    = pc_ctr;
    fetch_pc1_i    = pc_ctr + 32'd4;
    pc_ctr         = pc_ctr + 32'd8;
    #1;
    n       = fifo.size();
    full_m  = (n > DEPTH - 2);
    empty_m = (n == 0);
    lim     = si ? 1 : 2;
    pop_n   = (st || fl) ? 0 : ((n < lim) ? n : lim);
    e0 = '0;
    e1 = '0;
    if (pop_n >= 1) e0 = fifo[0];
    if (pop_n == 2) e1 = fifo[1];
    check("valid0", 64'(id_valid0_o), 64'(pop_n >= 1));
    check("valid1", 64'(id_valid1_o), 64'(pop_n == 2));
    check("slot0",  {id_inst0_o, id_pc0_o}, e0);
    check("slot1",  {id_inst1_o, id_pc1_o}, e1);
    check("full",   64'(ibuf_full_o),  64'(full_m));
    check("empty",  64'(ibuf_empty_o), 64'(empty_m));
`ifdef IBUF_PERF_CNT_EN
    check("perf_full",  64'(perf_full_cycles_o),  64'(perf_full_m));
    check("perf_empty", 64'(perf_empty_cycles_o), 64'(perf_empty_m));
`endif
    @(posedge clk);
    if (r) begin
      fifo.delete();
`ifdef IBUF_PERF_CNT_EN
      perf_full_m  = '0;
      perf_empty_m = '0;
`endif
    end else begin
`ifdef IBUF_PERF_CNT_EN
      if (full_m && fv != 2'b00 && perf_full_m != '1) perf_full_m++;
      if (empty_m && !st && perf_empty_m != '1) perf_empty_m++;
`endif
      if (fl) begin
        fifo.delete();
      end else begin
        repeat (pop_n) void'(fifo.pop_front());
        if (!full_m && fv[0])
          fifo.push_back('{inst: fetch_inst0_i, pc: fetch_pc0_i});
        if (!full_m && fv == 2'b11)
          fifo.push_back('{inst: fetch_inst1_i, pc: fetch_pc1_i});
      end
    end
  endtask

  function automatic logic [1:0] rand_fv();
    case ($urandom_range(2))
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  initial begin
    rst            = 1'b1;
    flush_i        = 1'b0;
    stall_i        = 1'b0;
    single_issue_i = 1'b0;
    fetch_valid_i  = 2'b00;
    fetch_inst0_i  = '0;
    fetch_inst1_i  = '0;
    fetch_pc0_i    = '0;
    fetch_pc1_i    = '0;
    pc_ctr         = 32'h1000;
`ifdef IBUF_PERF_CNT_EN
    perf_full_m  = '0;
    perf_empty_m = '0;
`endif
    repeat (2) @(posedge clk);

    // Dual push after reset, dual issue next cycle, then empty.
    step(0, 0, 0, 0, 2'b11);
    step(0, 0, 0, 0, 2'b00);
    step(0, 0, 0, 0, 2'b00);

    // Fill under stall until full; extra offers are dropped; drain in order.
    repeat (10) step(0, 0, 1, 0, 2'b11);
    repeat (9)  step(0, 0, 0, 0, 2'b00);

    // Three entries drained one per cycle by single issue.
    step(0, 0, 1, 0, 2'b11);
    step(0, 0, 1, 0, 2'b01);
    repeat (3) step(0, 0, 0, 1, 2'b00);
    step(0, 0, 0, 0, 2'b00);

    // Move head/tail to index 15, then a push and pop that straddle the wrap.
    step(1, 0, 0, 0, 2'b00);
    repeat (15) step(0, 0, 0, 0, 2'b01);
    step(0, 0, 0, 0, 2'b00);
    step(0, 0, 1, 0, 2'b11);
    step(0, 0, 0, 0, 2'b00);
    step(0, 0, 0, 0, 2'b00);

    // Flush with six entries and a same-cycle dual push.
    repeat (3) step(0, 0, 1, 0, 2'b11);
    step(0, 1, 0, 0, 2'b11);
    step(0, 0, 0, 0, 2'b00);

    // Reset mid-stream with eight entries.
    repeat (4) step(0, 0, 1, 0, 2'b11);
    step(1, 0, 0, 0, 2'b11);
    step(0, 0, 0, 0, 2'b00);

    // Random traffic with alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 1500; i++) begin
      logic fill_phase;
      fill_phase = ((i / 60) % 2) == 0;
      step($urandom_range(199) == 0,
           $urandom_range(39) == 0,
           $urandom_range(9) < (fill_phase ? 7 : 2),
           $urandom_range(3) == 0,
           rand_fv());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Dual-issue instruction buffer between the fetch stage and the decode (ID) stage.
- Accepts up to 2 instructions per cycle from fetch and holds them in a circular FIFO.
- Presents up to 2 instructions per cycle to decode.
- Consumes the pipeline controller's ibuffer flush and ID stall outputs. Drives a backpressure request to fetch.

Parameters:
- DEPTH, 16: number of entries. Must be a power of two and at least 4.
- PTR_W, 4: pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush_i  input  1  clear the buffer (from the controller's ibuffer flush output).
- stall_i  input  1  ID stall (controller stall bit 0). When 1, no entries are issued.
- single_issue_i  input  1  decode takes at most 1 instruction this cycle.
- fetch_valid_i  input  2  valid slots from fetch. Only 2'b00, 2'b01 or 2'b11 are legal.
- fetch_inst0_i  input  32  first fetched instruction.
- fetch_pc0_i  input  32  PC of the first fetched instruction.
- fetch_inst1_i  input  32  second fetched instruction.
- fetch_pc1_i  input  32  PC of the second fetched instruction.
- id_inst0_o  output  32  instruction at head.
- id_pc0_o  output  32  PC of the instruction at head.
- id_valid0_o  output  1  head slot valid and issued this cycle.
- id_inst1_o  output  32  instruction at head+1.
- id_pc1_o  output  32  PC of the instruction at head+1.
- id_valid1_o  output  1  head+1 slot valid and issued this cycle.
- ibuf_full_o  output  1  backpressure to fetch: fewer than 2 free entries.
- ibuf_empty_o  output  1  buffer holds no entries.

Behaviour:
- State:
  - Entry arrays inst_q[DEPTH] and pc_q[DEPTH].
  - head and tail, PTR_W bits each, wrapping modulo DEPTH.
  - count, PTR_W+1 bits, range 0..DEPTH.
- Reset (rst=1 at a clock edge): head=0, tail=0, count=0. Entry arrays are not reset.
- Outputs after reset:
  - id_valid0_o=0, id_valid1_o=0, ibuf_full_o=0, ibuf_empty_o=1.
  - id_inst*/id_pc* are don't-care, but must be driven 0 whenever the matching valid is 0.
- Outputs are combinational from registered state and are read at head and head+1 (mod DEPTH):
  - issue_avail = min(count, single_issue_i ? 1 : 2).
  - pop_num = (stall_i || flush_i) ? 0 : issue_avail.
  - id_valid0_o = (pop_num >= 1); id_valid1_o = (pop_num == 2).
- Push:
  - push_num = ibuf_full_o ? 0 : popcount(fetch_valid_i).
  - Entries are written at tail (slot 0) and tail+1 (slot 1).
  - Fetch must hold its instructions while ibuf_full_o=1. Slots offered while full are dropped by this block.
- Update when there is no flush:
  - head += pop_num.
  - tail += push_num.
  - count += push_num - pop_num.
- Same-cycle push and pop is allowed. The full check uses the current count, not the post-pop count.
- ibuf_full_o = (count > DEPTH-2). ibuf_empty_o = (count == 0).
- Flush (flush_i=1, rst=0):
  - head=0, tail=0, count=0 next cycle.
  - Pushes in the same cycle are discarded.
  - Both id_valid outputs are 0 in the flush cycle.
- Priority: rst, then flush_i, then normal operation.
- Wrap-around: pointer increments wrap naturally at DEPTH. A 2-entry push or pop straddling index DEPTH-1 to index 0 must work.
- Illegal fetch_valid_i=2'b10 is treated as 2'b00. An assertion fires under simulation only.
- count never exceeds DEPTH and never underflows. Assert both in simulation.

Optional Feature:
- Macro IBUF_PERF_CNT_EN.
- Defined:
  - Adds output perf_full_cycles_o (32 bits), which counts cycles with ibuf_full_o=1 && fetch_valid_i!=0.
  - Adds output perf_empty_cycles_o (32 bits), which counts cycles with ibuf_empty_o=1 && stall_i=0.
  - Both counters reset to 0 on rst, are unaffected by flush_i, and saturate at 32'hFFFFFFFF.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

Test Plan:
- Reset, then fetch_valid_i=2'b11 (pc 0x1000/0x1004) with stall_i=0 → next cycle id_valid0_o=1 (pc 0x1000) and id_valid1_o=1 (pc 0x1004). The cycle after that ibuf_empty_o=1.
- stall_i=1 held while pushing 2 per cycle → ibuf_full_o=1 once count reaches 15. Count stops at 15 or 16, never more. FIFO order is preserved after release.
- count=3 with single_issue_i=1 for 3 cycles → one instruction per cycle in PC order. id_valid1_o stays 0 throughout.
- Pre-advance head/tail to 15, then push 2 and pop 2 → entries at index 15 and index 0 issue in order and pointers wrap to 1.
- count=6, flush_i=1 with fetch_valid_i=2'b11 in the same cycle → both id_valid outputs are 0 that cycle. Next cycle count=0 and ibuf_empty_o=1; the fetched instructions are not stored.
- rst asserted mid-stream with count=8 → next cycle count=0, outputs at their reset values. With IBUF_PERF_CNT_EN defined, both perf counters read 0.
